// File: rtl/not1_checker.sv
// Stimulus/response checker for single-input inverters. It drives dut_a with an
// alternating 0/1 pattern, samples dut_y after a settle time and counts mismatches.
module not1_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_a,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       vec_idx,
  output logic [7:0]       first_fail_idx
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES);
  localparam logic [7:0] LAST_IDX = 8'(2 * NUM_PASSES - 1);
  localparam logic [7:0] NO_FAIL  = 8'hFF;

  // 8'hFF is reserved as the "no failure" marker, so the last index must stay below it.
  if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("not1_checker: SETTLE_CYCLES out of range 0..255");
  end
  if (NUM_PASSES < 1 || NUM_PASSES > 127 || (2 * NUM_PASSES - 1) > 254) begin : g_bad_passes
    $error("not1_checker: NUM_PASSES out of range 1..127");
  end
  if (ERR_W < 1) begin : g_bad_errw
    $error("not1_checker: ERR_W must be at least 1");
  end

  state_t     state;
  logic [7:0] cnt;
  logic       mismatch;

  // Case inequality makes an X or Z on dut_y count as a failure in simulation.
  assign mismatch = (dut_y !== ~dut_a);
  assign pass     = done && (err_count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      dut_a          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= '0;
      vec_idx        <= 8'd0;
      first_fail_idx <= NO_FAIL;
      cnt            <= 8'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dut_a          <= 1'b0;
            vec_idx        <= 8'd0;
            cnt            <= CNT_LOAD;
            err_count      <= '0;
            first_fail_idx <= NO_FAIL;
            busy           <= 1'b1;
            done           <= 1'b0;
            state          <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            if (mismatch) begin
              if (err_count != '1) begin
                err_count <= err_count + 1'b1;
              end
              if (first_fail_idx == NO_FAIL) begin
                first_fail_idx <= vec_idx;
              end
            end
            // The sample edge doubles as the edge that applies the next vector.
            if (vec_idx < LAST_IDX) begin
              dut_a   <= ~dut_a;
              vec_idx <= vec_idx + 8'd1;
              cnt     <= CNT_LOAD;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
